// File: rtl/traffic_gen_if.sv
// traffic_gen_if: control inputs and car-array outputs shared by game control, traffic_gen and the collision checker.
interface traffic_gen_if #(
    parameter int ROWS = 16,
    parameter int COLS = 16
);
    logic                      enable;
    logic                      clear;
    logic [ROWS-1:0][COLS-1:0] rA;
    logic                      step;
    modport master (output enable, clear, input rA, step);
    modport slave  (input enable, clear, output rA, step);
endinterface

// File: rtl/traffic_gen.sv
// traffic_gen: scrolls single-cell cars across lane rows at per-lane speeds, spawning at entry edges from an LFSR.
module traffic_gen #(
    parameter int              ROWS      = 16,
    parameter int              COLS      = 16,
    parameter int              TICK_DIV  = 25000,
    parameter logic [ROWS-1:0] LANE_MASK = 16'h7FFE,
    parameter logic [3:0]      DENSITY   = 4'd5,
    parameter int              MIN_GAP   = 2,
    parameter logic [15:0]     SEED      = 16'hACE1
) (
    input  logic         clk,
    input  logic         reset_n,
    traffic_gen_if.slave bus
);
    localparam int          PW       = $clog2(TICK_DIV);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;
    logic [PW-1:0]   prescaler;
    logic [1:0]      frame;
    logic [15:0]     lfsr;
    logic [15:0]     lfsr_nxt;
    logic            tick;
    logic [COLS-1:0] row_nxt [ROWS];
    assign tick     = bus.enable && prescaler == PW'(TICK_DIV - 1);
    assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    // Even rows enter at col 0 and scroll up; odd rows enter at COLS-1 and scroll down.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [3:0] nib;
        logic       gap_clr;
        logic       move;
        logic       in_bit;
        assign nib     = {lfsr[(r+3)%16], lfsr[(r+2)%16], lfsr[(r+1)%16], lfsr[r%16]};
        assign gap_clr = (r % 2 == 0) ? ~|bus.rA[r][MIN_GAP-1:0] : ~|bus.rA[r][COLS-1 -: MIN_GAP];
        assign move    = (r % 3 == 0) || (r % 3 == 1 && !frame[0]) || (r % 3 == 2 && frame == 2'd0);
        assign in_bit  = (nib < DENSITY) && gap_clr;
        assign row_nxt[r] = !LANE_MASK[r] ? '0 :
                            !move         ? bus.rA[r] :
                            (r % 2 == 0)  ? {bus.rA[r][COLS-2:0], in_bit} :
                                            {in_bit, bus.rA[r][COLS-1:1]};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rA    <= '0;
            bus.step  <= 1'b0;
            prescaler <= '0;
            frame     <= '0;
            lfsr      <= SEED_EFF;
        end else if (bus.clear) begin
            bus.rA    <= '0;
            bus.step  <= 1'b0;
            prescaler <= '0;
            frame     <= '0;
        end else if (bus.enable) begin
            bus.step  <= tick;
            prescaler <= tick ? '0 : prescaler + 1'b1;
            lfsr      <= lfsr_nxt;
            if (tick) begin
                frame <= frame + 2'd1;
                for (int i = 0; i < ROWS; i++) bus.rA[i] <= row_nxt[i];
            end
        end else begin
            bus.step <= 1'b0;
        end
    end
endmodule

// File: tb/tb_traffic_gen.sv
// tb_traffic_gen: directed scenarios for traffic_gen with a behavioural reference model of the car array.
module tb_traffic_gen;
    localparam logic [15:0] LANES = 16'h7FFE;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [15:0] m_rA [16];
    logic [15:0] m_lfsr;
    logic [1:0]  m_presc;
    logic [1:0]  m_frame;
    always #5 clk = ~clk;
    traffic_gen_if #(.ROWS(16), .COLS(16)) tif ();
    traffic_gen #(
        .TICK_DIV(4), .DENSITY(4'd15), .MIN_GAP(2), .SEED(16'h0001)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(tif)
    );
    function automatic logic [15:0] model_row(int r, logic [15:0] cur, logic [15:0] l, logic [1:0] f);
        logic [15:0] rot;
        logic go;
        logic busy;
        logic spawn;
        rot = (l >> r) | (l << (16 - r));
        go = (r % 3 == 0) || (r % 3 == 1 && f[0] == 1'b0) || (r % 3 == 2 && f == 2'd0);
        if (!LANES[r]) return 16'h0;
        if (!go) return cur;
        busy = 1'b0;
        for (int k = 0; k < 2; k++) busy = busy | ((r % 2) ? cur[15-k] : cur[k]);
        spawn = (rot[3:0] < 4'd15) && !busy;
        return (r % 2) ? {spawn, cur[15:1]} : {cur[14:0], spawn};
    endfunction
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) m_rA[i] <= 16'h0;
            m_lfsr  <= 16'h0001;
            m_presc <= 2'd0;
            m_frame <= 2'd0;
        end else if (tif.clear) begin
            for (int i = 0; i < 16; i++) m_rA[i] <= 16'h0;
            m_presc <= 2'd0;
            m_frame <= 2'd0;
        end else if (tif.enable) begin
            m_presc <= m_presc + 2'd1;
            m_lfsr  <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
            if (m_presc == 2'd3) begin
                m_frame <= m_frame + 2'd1;
                for (int i = 0; i < 16; i++) m_rA[i] <= model_row(i, m_rA[i], m_lfsr, m_frame);
            end
        end
    end
    task automatic test_reset();
        tif.enable = 1'b0;
        tif.clear = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tif.rA !== '0) begin
            n_fail++;
            $display("FAIL reset_rA: got %h expected 0", tif.rA);
        end
        n_checks++;
        if (tif.step !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_step: got %b expected 0", tif.step);
        end
        n_checks++;
        if (dut.lfsr !== 16'h0001) begin
            n_fail++;
            $display("FAIL reset_lfsr: got %h expected 0001", dut.lfsr);
        end
    endtask
    task automatic test_first_tick();
        logic [15:0] exp;
        tif.enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (tif.step !== (i == 4)) begin
                n_fail++;
                $display("FAIL first_step clk%0d: got %b expected %b", i, tif.step, i == 4);
            end
        end
        // lfsr at the tick is 16'h2D00: no 4 consecutive ones, so every lane spawns
        for (int r = 0; r < 16; r++) begin
            exp = (r == 0 || r == 15) ? 16'h0000 : (r % 2) ? 16'h8000 : 16'h0001;
            n_checks++;
            if (tif.rA[r] !== exp) begin
                n_fail++;
                $display("FAIL first_tick row%0d: got %h expected %h", r, tif.rA[r], exp);
            end
        end
    endtask
    task automatic test_step_period();
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (tif.step !== (i % 4 == 0)) begin
                n_fail++;
                $display("FAIL step_period clk%0d: got %b expected %b", i, tif.step, i % 4 == 0);
            end
        end
    endtask
    task automatic test_lane3();
        logic [15:0] old;
        for (int t = 0; t < 8; t++) begin
            old = tif.rA[3];
            repeat (4) @(negedge clk);
            n_checks++;
            if (tif.rA[3][14:0] !== old[15:1]) begin
                n_fail++;
                $display("FAIL lane3_shift t%0d: got %h expected low bits of %h", t, tif.rA[3], old >> 1);
            end
            n_checks++;
            if ($countones(tif.rA[3][15:13]) > 1) begin
                n_fail++;
                $display("FAIL lane3_gap t%0d: got %b expected at most one set", t, tif.rA[3][15:13]);
            end
            n_checks++;
            if (tif.rA[3] !== m_rA[3]) begin
                n_fail++;
                $display("FAIL lane3_model t%0d: got %h expected %h", t, tif.rA[3], m_rA[3]);
            end
            n_checks++;
            if (tif.rA[0] !== 16'h0 || tif.rA[15] !== 16'h0) begin
                n_fail++;
                $display("FAIL edge_rows t%0d: got %h/%h expected 0/0", t, tif.rA[0], tif.rA[15]);
            end
        end
    endtask
    task automatic test_speed();
        logic [15:0] o1, o2, o3;
        for (int g = 0; g < 4 && m_frame != 2'd0; g++) repeat (4) @(negedge clk);
        for (int t = 0; t < 4; t++) begin
            o1 = tif.rA[1];
            o2 = tif.rA[2];
            o3 = tif.rA[3];
            repeat (4) @(negedge clk);
            n_checks++;
            if (tif.rA[3][14:0] !== o3[15:1]) begin
                n_fail++;
                $display("FAIL speed_row3 t%0d: got %h from %h", t, tif.rA[3], o3);
            end
            n_checks++;
            if ((t % 2 == 0) ? (tif.rA[1][14:0] !== o1[15:1]) : (tif.rA[1] !== o1)) begin
                n_fail++;
                $display("FAIL speed_row1 t%0d: got %h from %h", t, tif.rA[1], o1);
            end
            n_checks++;
            if ((t == 0) ? (tif.rA[2][15:1] !== o2[14:0]) : (tif.rA[2] !== o2)) begin
                n_fail++;
                $display("FAIL speed_row2 t%0d: got %h from %h", t, tif.rA[2], o2);
            end
            for (int r = 1; r <= 3; r++) begin
                n_checks++;
                if (tif.rA[r] !== m_rA[r]) begin
                    n_fail++;
                    $display("FAIL speed_model row%0d t%0d: got %h expected %h", r, t, tif.rA[r], m_rA[r]);
                end
            end
        end
    endtask
    task automatic test_enable_hold();
        logic [15:0] snap [16];
        logic same;
        repeat (2) @(negedge clk);
        for (int r = 0; r < 16; r++) snap[r] = tif.rA[r];
        tif.enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (tif.step !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_step clk%0d: got %b expected 0", i, tif.step);
            end
        end
        same = 1'b1;
        for (int r = 0; r < 16; r++) if (tif.rA[r] !== snap[r]) same = 1'b0;
        n_checks++;
        if (!same) begin
            n_fail++;
            $display("FAIL hold_rA: got %h expected unchanged", tif.rA);
        end
        n_checks++;
        if (dut.prescaler !== 2'd2) begin
            n_fail++;
            $display("FAIL hold_prescaler: got %0d expected 2", dut.prescaler);
        end
        n_checks++;
        if (dut.lfsr !== m_lfsr) begin
            n_fail++;
            $display("FAIL hold_lfsr: got %h expected %h", dut.lfsr, m_lfsr);
        end
        tif.enable = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (tif.step !== (i == 2)) begin
                n_fail++;
                $display("FAIL resume_step clk%0d: got %b expected %b", i, tif.step, i == 2);
            end
        end
        for (int r = 0; r < 16; r++) begin
            n_checks++;
            if (tif.rA[r] !== m_rA[r]) begin
                n_fail++;
                $display("FAIL resume_model row%0d: got %h expected %h", r, tif.rA[r], m_rA[r]);
            end
        end
    endtask
    task automatic test_clear();
        int lat;
        repeat (3) @(negedge clk);
        tif.clear = 1'b1;
        @(negedge clk);
        tif.clear = 1'b0;
        n_checks++;
        if (tif.rA !== '0) begin
            n_fail++;
            $display("FAIL clear_rA: got %h expected 0", tif.rA);
        end
        n_checks++;
        if (tif.step !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_step: got %b expected 0", tif.step);
        end
        n_checks++;
        if (dut.frame !== 2'd0 || dut.prescaler !== 2'd0) begin
            n_fail++;
            $display("FAIL clear_counters: got frame %0d presc %0d expected 0 0", dut.frame, dut.prescaler);
        end
        n_checks++;
        if (dut.lfsr !== m_lfsr) begin
            n_fail++;
            $display("FAIL clear_lfsr: got %h expected %h", dut.lfsr, m_lfsr);
        end
        lat = 0;
        while (lat < 10 && tif.step !== 1'b1) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL clear_latency: got %0d clks expected 4", lat);
        end
        for (int r = 1; r <= 2; r++) begin
            n_checks++;
            if (tif.rA[r] !== m_rA[r]) begin
                n_fail++;
                $display("FAIL clear_first row%0d: got %h expected %h", r, tif.rA[r], m_rA[r]);
            end
        end
    endtask
    task automatic test_async_reset();
        repeat (16) @(negedge clk);
        n_checks++;
        if (tif.rA === '0) begin
            n_fail++;
            $display("FAIL async_pre: got %h expected nonzero", tif.rA);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (tif.rA !== '0 || tif.step !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %h step %b expected 0 0", tif.rA, tif.step);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask
    initial begin
        test_reset();
        test_first_tick();
        test_step_period();
        test_lane3();
        test_speed();
        test_enable_hold();
        test_clear();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
